// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: machine word width, reset PC, opcode encoding and
// the fetch-queue entry layout used between Fetch and Decode.
package lc3_pkg;

    localparam int LC3_W = 16;
    localparam logic [LC3_W-1:0] LC3_RESET_PC = 16'h3000;

    typedef logic [LC3_W-1:0] word_t;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RES  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_t;

    // One queued instruction together with the address following it.
    typedef struct packed {
        word_t instr;
        word_t npc;
    } fetch_entry_t;

    function automatic word_t pc_inc(input word_t p);
        return p + word_t'(1);
    endfunction

    function automatic opcode_t opcode_of(input word_t instr);
        return opcode_t'(instr[15:12]);
    endfunction

endpackage

// File: rtl/lc3_fetch_fifo.sv
// Circular instruction queue between Fetch and Decode; flush empties it and
// wins over a simultaneous push or pop.
module lc3_fetch_fifo
    import lc3_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output fetch_entry_t           head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
        do_pop  = pop_i && !flush_i && (count_q != '0);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign occupancy_o = count_q;
    assign head_o      = mem_q[rd_ptr_q];

endmodule

// File: rtl/lc3_fetch_buffer.sv
// LC-3 fetch stage with a credit-limited instruction queue and branch redirect.
// Optional pop counter output fetch_count when LC3_FETCH_STATS_EN is defined.
module lc3_fetch_buffer
    import lc3_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [LC3_W-1:0] RESET_PC = LC3_RESET_PC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_fetch,
    input  logic             br_taken,
    input  logic [LC3_W-1:0] taken_address,
    output logic             instrmem_rd,
    output logic [LC3_W-1:0] pc,
    input  logic [LC3_W-1:0] Imem_dout,
    output logic [LC3_W-1:0] dout,
    output logic [LC3_W-1:0] npc_out,
    output logic             dout_valid,
    input  logic             enable_decode
`ifdef LC3_FETCH_STATS_EN
    ,
    output logic [LC3_W-1:0] fetch_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    word_t         pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] occupancy;
    logic          credit_ok;
    logic          issue;
    logic          push;
    logic          pop;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

    // Queued plus outstanding requests never exceed DEPTH, so a push always has room.
    always_comb begin
        credit_ok = (occupancy + CW'(inflight_q)) < CW'(DEPTH);
        issue     = enable_fetch && !br_taken && !reset && credit_ok;
        push      = inflight_q && !br_taken;
        pop       = dout_valid && enable_decode;
    end

    // pc_q has already advanced past the issued address, so it is that entry's npc.
    always_comb begin
        push_data.instr = Imem_dout;
        push_data.npc   = pc_q;
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = issue;
        if (br_taken) begin
            pc_d = taken_address;
        end else if (issue) begin
            pc_d = pc_inc(pc_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    lc3_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i      (clock),
        .rst_i      (reset),
        .flush_i    (br_taken),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (pop),
        .occupancy_o(occupancy),
        .head_o     (head)
    );

    always_comb begin
        dout_valid  = (occupancy != '0);
        instrmem_rd = issue;
        pc          = pc_q;
        dout        = dout_valid ? head.instr : '0;
        npc_out     = dout_valid ? head.npc : '0;
    end

`ifdef LC3_FETCH_STATS_EN
    logic [LC3_W-1:0] fetch_count_q, fetch_count_d;

    // A redirect suppresses the pop, so flushed entries are never counted.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (pop && !br_taken) fetch_count_d = fetch_count_q + LC3_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_lc3_fetch_buffer.sv
// Scoreboard bench for lc3_fetch_buffer: a behavioural model predicts issues and
// queue contents; a simple memory model answers every read the DUT makes.
module tb_lc3_fetch_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] npc;
    } ent_t;

    logic        clock;
    logic        reset;
    logic        enable_fetch;
    logic        br_taken;
    logic [15:0] taken_address;
    logic        instrmem_rd;
    logic [15:0] pc;
    logic [15:0] Imem_dout;
    logic [15:0] dout;
    logic [15:0] npc_out;
    logic        dout_valid;
    logic        enable_decode;
`ifdef LC3_FETCH_STATS_EN
    logic [15:0] fetch_count;
`endif

    lc3_fetch_buffer #(
        .DEPTH(DEPTH),
        .RESET_PC(16'h3000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable_fetch (enable_fetch),
        .br_taken     (br_taken),
        .taken_address(taken_address),
        .instrmem_rd  (instrmem_rd),
        .pc           (pc),
        .Imem_dout    (Imem_dout),
        .dout         (dout),
        .npc_out      (npc_out),
        .dout_valid   (dout_valid),
        .enable_decode(enable_decode)
`ifdef LC3_FETCH_STATS_EN
        ,
        .fetch_count  (fetch_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    ent_t        sb[$];
    logic [15:0] m_pc;
    logic        m_inflight;
    logic [15:0] m_infl_pc;

    logic        obs_rd, obs_valid;
    logic [15:0] obs_pc, obs_dout, obs_npc;

    logic [15:0] imem_addr;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hA5C3;
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: one-cycle read latency at whatever address was presented.
    always @(posedge clock) imem_addr <= pc;
    assign Imem_dout = memfn(imem_addr);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        sb.delete();
        m_pc       = 16'h3000;
        m_inflight = 1'b0;
        m_infl_pc  = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable_fetch = 1'b0;
        br_taken = 1'b0;
        taken_address = 16'h0000;
        enable_decode = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic ef, input logic bt, input logic [15:0] ta, input logic ed);
        logic        exp_rd;
        logic        exp_valid;
        logic [15:0] exp_dout, exp_npc;
        ent_t        e;
        enable_fetch = ef;
        br_taken = bt;
        taken_address = ta;
        enable_decode = ed;
        #1;
        exp_rd    = ef && !bt && ((sb.size() + (m_inflight ? 1 : 0)) < DEPTH);
        exp_valid = (sb.size() != 0);
        exp_dout  = 16'h0000;
        exp_npc   = 16'h0000;
        if (exp_valid) begin
            e = sb[0];
            exp_dout = e.instr;
            exp_npc  = e.npc;
        end
        obs_rd = instrmem_rd;
        obs_valid = dout_valid;
        obs_pc = pc;
        obs_dout = dout;
        obs_npc = npc_out;
        checks += 5;
        if (obs_rd !== exp_rd) begin
            errors++;
            $display("FAIL sb_rd t=%0t got %b expected %b", $time, obs_rd, exp_rd);
        end
        if (obs_pc !== m_pc) begin
            errors++;
            $display("FAIL sb_pc t=%0t got %h expected %h", $time, obs_pc, m_pc);
        end
        if (obs_valid !== exp_valid) begin
            errors++;
            $display("FAIL sb_valid t=%0t got %b expected %b", $time, obs_valid, exp_valid);
        end
        if (obs_dout !== exp_dout) begin
            errors++;
            $display("FAIL sb_dout t=%0t got %h expected %h", $time, obs_dout, exp_dout);
        end
        if (obs_npc !== exp_npc) begin
            errors++;
            $display("FAIL sb_npc t=%0t got %h expected %h", $time, obs_npc, exp_npc);
        end
        if (bt) begin
            sb.delete();
            m_pc = ta;
            m_inflight = 1'b0;
        end else begin
            if (exp_valid && ed) sb.delete(0);
            if (m_inflight) begin
                e.instr = memfn(m_infl_pc);
                e.npc   = m_infl_pc + 16'h0001;
                sb.push_back(e);
            end
            if (exp_rd) begin
                m_infl_pc = m_pc;
                m_pc = m_pc + 16'h0001;
            end
            m_inflight = exp_rd;
        end
        @(negedge clock);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || m_inflight) && n < 20) begin
            step(1'b0, 1'b0, 16'h0000, 1'b1);
            n++;
        end
        checks++;
        if (sb.size() != 0 || m_inflight) begin
            errors++;
            $display("FAIL drain_timeout entries left %0d required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable_fetch = 1'b1;
        br_taken = 1'b0;
        taken_address = 16'h0000;
        enable_decode = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
        checks += 5;
        if (pc !== 16'h3000) begin errors++; $display("FAIL reset_pc got %h expected 3000", pc); end
        if (instrmem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b expected 0", instrmem_rd); end
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", dout_valid); end
        if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h expected 0000", dout); end
        if (npc_out !== 16'h0000) begin errors++; $display("FAIL reset_npc got %h expected 0000", npc_out); end
        reset = 1'b0;
        enable_fetch = 1'b0;
        enable_decode = 1'b0;
        model_reset();
        @(negedge clock);
    endtask

    task automatic test_stream();
        int first_valid = -1;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b1);
            checks++;
            if (obs_rd !== 1'b1 || obs_pc !== 16'h3000 + 16'(k)) begin
                errors++;
                $display("FAIL stream_issue k=%0d got rd=%b pc=%h expected rd=1 pc=%h", k, obs_rd, obs_pc, 16'h3000 + 16'(k));
            end
            if (first_valid < 0 && obs_valid) begin
                first_valid = k;
                checks++;
                if (obs_npc !== 16'h3001) begin
                    errors++;
                    $display("FAIL stream_first_npc got %h expected 3001", obs_npc);
                end
            end
        end
        checks++;
        if (first_valid != 2) begin
            errors++;
            $display("FAIL stream_latency got %0d expected 2", first_valid);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int issues = 0;
        int pops = 0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b0);
            if (obs_rd) issues++;
        end
        checks += 3;
        if (issues != DEPTH) begin errors++; $display("FAIL bp_issues got %0d expected %0d", issues, DEPTH); end
        if (obs_rd !== 1'b0) begin errors++; $display("FAIL bp_rd_idle got %b expected 0", obs_rd); end
        if (obs_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b expected 1", obs_valid); end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b1);
            if (obs_valid) begin
                checks++;
                if (obs_npc !== 16'h3001 + 16'(pops)) begin
                    errors++;
                    $display("FAIL bp_order got %h expected %h", obs_npc, 16'h3001 + 16'(pops));
                end
                pops++;
            end
        end
        checks++;
        if (pops != DEPTH) begin errors++; $display("FAIL bp_pops got %0d expected %0d", pops, DEPTH); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 16'h4000, 1'b1);
        checks += 2;
        if (obs_rd !== 1'b0) begin errors++; $display("FAIL redir_rd got %b expected 0", obs_rd); end
        if (obs_valid !== 1'b1) begin errors++; $display("FAIL redir_pre_valid got %b expected 1", obs_valid); end
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        checks += 2;
        if (obs_valid !== 1'b0) begin errors++; $display("FAIL redir_flushed got %b expected 0", obs_valid); end
        if (obs_rd !== 1'b1 || obs_pc !== 16'h4000) begin
            errors++;
            $display("FAIL redir_issue got rd=%b pc=%h expected rd=1 pc=4000", obs_rd, obs_pc);
        end
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (obs_valid !== 1'b0) begin errors++; $display("FAIL redir_drop got %b expected 0", obs_valid); end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks += 2;
        if (obs_npc !== 16'h4001) begin errors++; $display("FAIL redir_npc got %h expected 4001", obs_npc); end
        if (obs_dout !== memfn(16'h4000)) begin errors++; $display("FAIL redir_dout got %h expected %h", obs_dout, memfn(16'h4000)); end
        drain();
    endtask

    task automatic test_pc_wrap();
        step(1'b0, 1'b1, 16'hFFFF, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (obs_rd !== 1'b1 || obs_pc !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_issue got rd=%b pc=%h expected rd=1 pc=ffff", obs_rd, obs_pc);
        end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (obs_pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h expected 0000", obs_pc); end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (obs_valid !== 1'b1 || obs_npc !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_npc got valid=%b npc=%h expected valid=1 npc=0000", obs_valid, obs_npc);
        end
        drain();
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 16'h0000, 1'b0);
        enable_fetch = 1'b1;
        reset = 1'b1;
        #1;
        checks += 5;
        if (pc !== 16'h3000) begin errors++; $display("FAIL midrst_pc got %h expected 3000", pc); end
        if (instrmem_rd !== 1'b0) begin errors++; $display("FAIL midrst_rd got %b expected 0", instrmem_rd); end
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b expected 0", dout_valid); end
        if (dout !== 16'h0000) begin errors++; $display("FAIL midrst_dout got %h expected 0000", dout); end
        if (npc_out !== 16'h0000) begin errors++; $display("FAIL midrst_npc got %h expected 0000", npc_out); end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (obs_rd !== 1'b1 || obs_pc !== 16'h3000) begin
            errors++;
            $display("FAIL midrst_issue got rd=%b pc=%h expected rd=1 pc=3000", obs_rd, obs_pc);
        end
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (obs_npc !== 16'h3001) begin errors++; $display("FAIL midrst_npc_after got %h expected 3001", obs_npc); end
        drain();
    endtask

    task automatic test_random();
        logic ef, bt, ed;
        logic [15:0] ta;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            ef = ($urandom_range(0, 3) != 0);
            ed = ($urandom_range(0, 2) != 0);
            bt = ($urandom_range(0, 15) == 0);
            ta = 16'($urandom_range(0, 65535));
            step(ef, bt, ta, ed);
        end
        drain();
    endtask

`ifdef LC3_FETCH_STATS_EN
    task automatic test_stats();
        int pops = 0;
        int n = 0;
        do_reset();
        #1;
        checks++;
        if (fetch_count !== 16'h0000) begin errors++; $display("FAIL stats_reset got %0d expected 0", fetch_count); end
        @(negedge clock);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 16'h0000, 1'b0);
        while (pops < 5 && n < 30) begin
            step(1'b1, 1'b0, 16'h0000, 1'b1);
            if (obs_valid) pops++;
            n++;
        end
        step(1'b1, 1'b1, 16'h5000, 1'b1);
        n = 0;
        while (pops < 7 && n < 30) begin
            step(1'b1, 1'b0, 16'h0000, (pops < 7));
            if (obs_valid) pops++;
            n++;
        end
        enable_decode = 1'b0;
        #1;
        checks++;
        if (pops != 7 || fetch_count !== 16'd7) begin
            errors++;
            $display("FAIL stats_count got %0d (pops seen %0d) expected 7", fetch_count, pops);
        end
        @(negedge clock);
        do_reset();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_pc_wrap();
        test_reset_midop();
        test_random();
`ifdef LC3_FETCH_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
